// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the acc_cpu accumulator processor.
//   OPC_W     : opcode field width (upper bits of every instruction word)
//   opcode_e  : instruction opcodes, also used by the bench to assemble programs
//   state_e   : control FSM encodings (FETCH -> EXEC -> FETCH, EXEC -> HALT)
package acc_cpu_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 4'h0,
    OP_LDI = 4'h1,
    OP_LD  = 4'h2,
    OP_ST  = 4'h3,
    OP_ADD = 4'h4,
    OP_SUB = 4'h5,
    OP_AND = 4'h6,
    OP_OR  = 4'h7,
    OP_XOR = 4'h8,
    OP_JMP = 4'h9,
    OP_JZ  = 4'hA,
    OP_JC  = 4'hB,
    OP_IN  = 4'hC,
    OP_OUT = 4'hD,
    OP_HLT = 4'hE,
    OP_RSV = 4'hF   // reserved, executes as NOP
  } opcode_e;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU for acc_cpu.
//   op     in  opcode of the instruction in EXEC
//   acc    in  accumulator value
//   r      in  selected register value
//   c_in   in  current carry flag (passed through for non-arithmetic ops)
//   result out new accumulator value (acc for ops the ALU does not handle)
//   c_out  out new carry: ADD carry-out, SUB borrow, cleared by logic ops
//   z_out  out result == 0
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] r,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic              c_out,
  output logic              z_out
);

  logic [DATA_W:0] sum;

  assign sum = {1'b0, acc} + {1'b0, r};

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    result = acc;
    c_out  = c_in;
    case (op)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        c_out  = sum[DATA_W];
      end
      OP_SUB: begin
        result = acc - r;
        c_out  = (acc < r);
      end
      OP_AND: begin
        result = acc & r;
        c_out  = 1'b0;
      end
      OP_OR: begin
        result = acc | r;
        c_out  = 1'b0;
      end
      OP_XOR: begin
        result = acc ^ r;
        c_out  = 1'b0;
      end
      default: ;
    endcase
  end

  assign z_out = (result == '0);

endmodule

// File: rtl/acc_cpu.sv
// acc_cpu: parametrised multi-cycle accumulator processor.
// Each instruction takes a FETCH cycle and one EXEC cycle; IN and OUT stay in
// EXEC until their valid/ready handshake completes. HLT parks the core in HALT.
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   imem_addr   instruction address (= pc); imem_data returns the word combinationally
//   in_data/in_valid/in_ready     input port, consumed by IN
//   out_data/out_valid/out_ready  output port, driven by OUT (out_data = acc)
//   acc, flag_z, flag_c, halted   architectural state visibility
module acc_cpu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,   // must be <= DATA_W
  parameter int NREG   = 4    // power of two, >= 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic [OPC_W+DATA_W-1:0] imem_data,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       acc,
  output logic                    flag_z,
  output logic                    flag_c,
  output logic                    halted
);

  localparam int INSTR_W = OPC_W + DATA_W;
  localparam int RIDX_W  = $clog2(NREG);

  state_e              state, state_d;
  logic [ADDR_W-1:0]   pc;
  logic [INSTR_W-1:0]  ir;
  logic [DATA_W-1:0]   regs [NREG];

  opcode_e             opc;
  logic [DATA_W-1:0]   operand;
  logic [RIDX_W-1:0]   ridx;
  logic [DATA_W-1:0]   r_val;
  logic [ADDR_W-1:0]   jmp_target;
  logic                exec;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_c, alu_z;

  // Instruction decode. Register index and jump target use only the low
  // operand bits; the upper bits are ignored.
  assign opc        = opcode_e'(ir[INSTR_W-1:DATA_W]);
  assign operand    = ir[DATA_W-1:0];
  assign ridx       = operand[RIDX_W-1:0];
  assign jmp_target = operand[ADDR_W-1:0];
  assign r_val      = regs[ridx];
  assign exec       = (state == S_EXEC);

  // Handshake strobes are pure decodes of state/ir so they rise in the first
  // EXEC cycle and fall in the cycle after the transfer.
  assign in_ready  = exec && (opc == OP_IN);
  assign out_valid = exec && (opc == OP_OUT);
  assign out_data  = acc;
  assign halted    = (state == S_HALT);
  assign imem_addr = pc;

  acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (opc),
    .acc    (acc),
    .r      (r_val),
    .c_in   (flag_c),
    .result (alu_result),
    .c_out  (alu_c),
    .z_out  (alu_z)
  );

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state;
    case (state)
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        case (opc)
          OP_HLT:  state_d = S_HALT;
          OP_IN:   if (in_valid)  state_d = S_FETCH;
          OP_OUT:  if (out_ready) state_d = S_FETCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_HALT:  state_d = S_HALT;   // absorbing until reset
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_d;
  end

  // ---------------------------------------------------------------------------
  // pc / ir / accumulator / flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= '0;
      ir     <= '0;
      acc    <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          ir <= imem_data;
          pc <= pc + ADDR_W'(1);   // wraps naturally at 2**ADDR_W
        end
        S_EXEC: begin
          case (opc)
            OP_LDI: begin
              acc    <= operand;
              flag_z <= (operand == '0);
            end
            OP_LD: begin
              acc    <= r_val;
              flag_z <= (r_val == '0);
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              acc    <= alu_result;
              flag_c <= alu_c;
              flag_z <= alu_z;
            end
            // pc already points past the jump, so an untaken branch falls through.
            OP_JMP: pc <= jmp_target;
            OP_JZ:  if (flag_z) pc <= jmp_target;
            OP_JC:  if (flag_c) pc <= jmp_target;
            OP_IN: begin
              if (in_valid) begin
                acc    <= in_data;
                flag_z <= (in_data == '0);
              end
            end
            default: ;   // NOP, ST, OUT, HLT, reserved: no acc/flag change
          endcase
        end
        default: ;       // HALT: everything frozen
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  // NOTE: the register file is small and architecturally defined as zero
  // after reset, so it is built from flops and cleared; a RAM macro would not
  // be resettable this way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (exec && (opc == OP_ST)) begin
      regs[ridx] <= acc;
    end
  end

endmodule

// File: tb/tb_acc_cpu.sv
// Self-checking bench for acc_cpu. Two instances share clock, reset and the
// handshake inputs: dut_a uses default parameters, dut_b uses DATA_W=16,
// ADDR_W=8, NREG=8. Programs are written into prog_op/prog_arg, encoded into
// each instance's instruction memory, and executed by an instruction-level
// reference model that pushes expected OUT beats into a queue. A monitor pops
// and compares whenever an OUT transfer happens; final state is compared on halt.
module tb_acc_cpu;
  import acc_cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared handshake inputs
  logic [7:0]  in_data;
  logic        in_valid;
  logic        out_ready;

  // instance A (8/5/4)
  logic [4:0]  imem_addr_a;
  logic [11:0] imem_data_a;
  logic        in_ready_a, out_valid_a, flag_z_a, flag_c_a, halted_a;
  logic [7:0]  out_data_a, acc_a;
  logic [11:0] imem_a [32];

  // instance B (16/8/8)
  logic [7:0]  imem_addr_b;
  logic [19:0] imem_data_b;
  logic [15:0] in_data_b;
  logic        in_ready_b, out_valid_b, flag_z_b, flag_c_b, halted_b;
  logic [15:0] out_data_b, acc_b;
  logic [19:0] imem_b [256];

  assign imem_data_a = imem_a[imem_addr_a];
  assign imem_data_b = imem_b[imem_addr_b];
  assign in_data_b   = {8'h00, in_data};

  acc_cpu dut_a (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr_a), .imem_data(imem_data_a),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .acc(acc_a), .flag_z(flag_z_a), .flag_c(flag_c_a), .halted(halted_a)
  );

  acc_cpu #(.DATA_W(16), .ADDR_W(8), .NREG(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr_b), .imem_data(imem_data_b),
    .in_data(in_data_b), .in_valid(in_valid), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .acc(acc_b), .flag_z(flag_z_b), .flag_c(flag_c_b), .halted(halted_b)
  );

  // program source, stimulus and scoreboard state
  int prog_op [256];
  int prog_arg[256];
  int in_vals[$];
  int drv_in[$];
  int exp_a[$];
  int exp_b[$];
  int n_checks = 0;
  int n_err    = 0;
  bit drv_en   = 1'b0;
  bit mon_en_a = 1'b0;
  bit mon_en_b = 1'b0;
  int vpct = 100;
  int rpct = 100;
  int in_ready_cyc, out_valid_cyc, out_beats;
  logic       prev_ov_a;
  logic [7:0] prev_od_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin
      prog_op[i]  = int'(OP_HLT);
      prog_arg[i] = 0;
    end
    in_vals.delete();
  endtask

  task automatic set(input int addr, input opcode_e op, input int arg);
    prog_op[addr]  = int'(op);
    prog_arg[addr] = arg;
  endtask

  task automatic load_imem();
    for (int i = 0; i < 32; i++)  imem_a[i] = {4'(prog_op[i]), 8'(prog_arg[i])};
    for (int i = 0; i < 256; i++) imem_b[i] = {4'(prog_op[i]), 16'(prog_arg[i])};
  endtask

  // Instruction-level reference: runs the program one instruction at a time
  // with integer arithmetic, pushing each OUT value to the selected queue.
  task automatic model_run(input int dw, input int aw, input int nreg, input int sel,
                           output bit ok, output int m_acc, output int m_z,
                           output int m_c, output int m_pc, output int m_n);
    int regs[8];
    int mask  = (1 << dw) - 1;
    int depth = 1 << aw;
    int pc = 0, a_v = 0, z = 0, c = 0, k = 0, a, r, op;
    foreach (regs[i]) regs[i] = 0;
    ok = 1'b0;
    m_n = 0;
    for (int step = 0; step < 300 && !ok; step++) begin
      op = prog_op[pc];
      a  = prog_arg[pc] & mask;
      r  = a % nreg;
      pc = (pc + 1) % depth;
      m_n++;
      case (op)
        1:  begin a_v = a;        z = (a_v == 0); end
        2:  begin a_v = regs[r];  z = (a_v == 0); end
        3:  regs[r] = a_v;
        4:  begin a_v = a_v + regs[r]; c = (a_v > mask); a_v = a_v & mask; z = (a_v == 0); end
        5:  begin c = (a_v < regs[r]); a_v = (a_v - regs[r]) & mask; z = (a_v == 0); end
        6:  begin a_v = a_v & regs[r]; c = 0; z = (a_v == 0); end
        7:  begin a_v = a_v | regs[r]; c = 0; z = (a_v == 0); end
        8:  begin a_v = a_v ^ regs[r]; c = 0; z = (a_v == 0); end
        9:  pc = a % depth;
        10: if (z != 0) pc = a % depth;
        11: if (c != 0) pc = a % depth;
        12: begin
          a_v = ((k < in_vals.size()) ? in_vals[k] : 0) & mask;
          k++;
          z = (a_v == 0);
        end
        13: if (sel == 0) exp_a.push_back(a_v); else exp_b.push_back(a_v);
        14: ok = 1'b1;
        default: ;
      endcase
    end
    m_acc = a_v; m_z = z; m_c = c; m_pc = pc;
  endtask

  // Driver: changes handshake inputs 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (drv_en) begin
      in_valid  = ($urandom_range(0, 99) < vpct);
      in_data   = (in_valid && drv_in.size() > 0) ? 8'(drv_in[0]) : 8'($urandom);
      out_ready = ($urandom_range(0, 99) < rpct);
    end
  end

  // Monitor A: samples on the falling edge; a handshake seen here completes
  // at the following rising edge.
  always @(negedge clk) begin
    if (rst_n && mon_en_a) begin
      if (out_valid_a && prev_ov_a) check("out_data_stable", out_data_a, prev_od_a);
      if (out_valid_a && out_ready) begin
        out_beats++;
        if (exp_a.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL out_beat_a: actual=%0h required=no beat", out_data_a);
        end else begin
          check("out_data_a", out_data_a, exp_a.pop_front());
        end
      end
      if (in_valid && in_ready_a && drv_in.size() > 0) drv_in.delete(0);
      prev_ov_a = out_valid_a && !out_ready;
      prev_od_a = out_data_a;
      if (in_ready_a)  in_ready_cyc++;
      if (out_valid_a) out_valid_cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && mon_en_b && out_valid_b && out_ready) begin
      out_beats++;
      if (exp_b.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL out_beat_b: actual=%0h required=no beat", out_data_b);
      end else begin
        check("out_data_b", out_data_b, exp_b.pop_front());
      end
    end
  end

  // Resets both cores, runs the selected one to HALT and compares final state.
  task automatic run_prog(input int sel, input bit manual, input int max_cyc);
    bit ok, done;
    int m_acc, m_z, m_c, m_pc, m_n, cyc;
    load_imem();
    exp_a.delete();
    exp_b.delete();
    model_run(sel ? 16 : 8, sel ? 8 : 5, sel ? 8 : 4, sel, ok, m_acc, m_z, m_c, m_pc, m_n);
    drv_in = in_vals;
    drv_en = !manual;
    @(posedge clk);
    #1 rst_n = 1'b0;
    prev_ov_a = 1'b0;
    out_beats = 0;
    mon_en_a  = (sel == 0);
    mon_en_b  = (sel == 1);
    #2;
    check("rst_halted_a", halted_a, 1'b0);
    check("rst_in_ready_a", in_ready_a, 1'b0);
    check("rst_out_valid_a", out_valid_a, 1'b0);
    check("rst_imem_addr_a", imem_addr_a, 0);
    check("rst_acc_a", acc_a, 0);
    check("rst_flags_a", {flag_z_a, flag_c_a}, 0);
    check("rst_imem_addr_b", imem_addr_b, 0);
    check("rst_halted_b", halted_b, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < max_cyc) begin
      @(posedge clk);
      #1;
      cyc++;
      done = sel ? halted_b : halted_a;
    end
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL halt_timeout: actual=not halted after %0d cycles required=halted", cyc);
    end else begin
      if (!manual && vpct == 100 && rpct == 100) check("cycles_to_halt", cyc, 2 * m_n);
      repeat (3) @(posedge clk);
      #1;
      if (sel == 0) begin
        check("halt_acc_a", acc_a, m_acc);
        check("halt_z_a", flag_z_a, m_z[0]);
        check("halt_c_a", flag_c_a, m_c[0]);
        check("halt_pc_a", imem_addr_a, m_pc);
        check("halt_held_a", halted_a, 1'b1);
        check("halt_strobes_a", {in_ready_a, out_valid_a}, 0);
        check("beats_left_a", exp_a.size(), 0);
      end else begin
        check("halt_acc_b", acc_b, m_acc);
        check("halt_z_b", flag_z_b, m_z[0]);
        check("halt_c_b", flag_c_b, m_c[0]);
        check("halt_pc_b", imem_addr_b, m_pc);
        check("halt_held_b", halted_b, 1'b1);
        check("beats_left_b", exp_b.size(), 0);
      end
    end
    drv_en   = 1'b0;
    mon_en_a = 1'b0;
    mon_en_b = 1'b0;
  endtask

  initial begin
    bit ok;
    int d0, d1, d2, d3, d4, tries;

    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    clear_prog();
    load_imem();

    // 1: add then output, no stalls
    clear_prog();
    set(0, OP_LDI, 5); set(1, OP_ST, 1); set(2, OP_LDI, 3);
    set(3, OP_ADD, 1); set(4, OP_OUT, 0); set(5, OP_HLT, 0);
    vpct = 100; rpct = 100;
    run_prog(0, 1'b0, 200);
    check("t1_beats", out_beats, 1);
    check("t1_acc", acc_a, 8'h08);

    // 2: carry/zero from ADD, JC taken, SUB borrow
    clear_prog();
    set(0, OP_LDI, 8'hFF); set(1, OP_ST, 2); set(2, OP_LDI, 1); set(3, OP_ST, 3);
    set(4, OP_ADD, 2); set(5, OP_OUT, 0); set(6, OP_JC, 8'h10);
    set(16, OP_SUB, 3); set(17, OP_OUT, 0); set(18, OP_HLT, 0);
    run_prog(0, 1'b0, 200);
    check("t2_acc", acc_a, 8'hFF);
    check("t2_carry", flag_c_a, 1'b1);
    check("t2_pc", imem_addr_a, 19);

    // 3: handshake stalls driven by hand
    clear_prog();
    set(0, OP_IN, 0); set(1, OP_OUT, 0); set(2, OP_HLT, 0);
    in_vals.push_back(8'h2A);
    in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h2A;
    in_ready_cyc = 0; out_valid_cyc = 0;
    fork
      run_prog(0, 1'b1, 300);
      begin
        for (int i = 0; i < 100 && in_ready_cyc < 5; i++) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 100 && out_valid_cyc < 3; i++) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
      end
    join
    check("t3_in_ready_cycles", in_ready_cyc, 6);
    check("t3_out_valid_cycles", out_valid_cyc, 4);
    check("t3_acc", acc_a, 8'h2A);

    // 4: pc wrap 31 -> 0, then a countdown loop of exactly three passes
    clear_prog();
    set(0, OP_LD, 0); set(1, OP_JZ, 28); set(2, OP_LDI, 1); set(3, OP_ST, 1);
    set(4, OP_LDI, 3); set(5, OP_OUT, 0); set(6, OP_SUB, 1); set(7, OP_JZ, 9);
    set(8, OP_JMP, 5); set(9, OP_HLT, 0);
    set(28, OP_LDI, 1); set(29, OP_ST, 0); set(30, OP_NOP, 0); set(31, OP_NOP, 0);
    vpct = 100; rpct = 100;
    run_prog(0, 1'b0, 400);
    check("t4_beats", out_beats, 3);

    // 5: asynchronous reset while stalled in OUT
    clear_prog();
    set(0, OP_OUT, 0); set(1, OP_HLT, 0);
    load_imem();
    drv_en = 1'b0; mon_en_a = 1'b0; mon_en_b = 1'b0;
    out_ready = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 20 && !out_valid_a; i++) begin @(posedge clk); #1; end
    check("t5_out_valid_stall", out_valid_a, 1'b1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5_out_valid", out_valid_a, 1'b0);
    check("t5_in_ready", in_ready_a, 1'b0);
    check("t5_halted", halted_a, 1'b0);
    check("t5_imem_addr", imem_addr_a, 0);
    check("t5_acc_flags", {acc_a, flag_z_a, flag_c_a}, 0);
    @(posedge clk); #1;
    check("t5_addr_in_reset", imem_addr_a, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5_restart_addr", imem_addr_a, 1);
    check("t5_restart_out", out_valid_a, 1'b1);

    // 6: wide configuration
    clear_prog();
    set(0, OP_LDI, 16'hFFFF); set(1, OP_ST, 7); set(2, OP_LDI, 0); set(3, OP_LD, 7);
    set(4, OP_OUT, 0); set(5, OP_LDI, 1); set(6, OP_ADD, 7); set(7, OP_OUT, 0);
    set(8, OP_JMP, 8'hC8); set(200, OP_LDI, 16'h1234); set(201, OP_OUT, 0);
    set(202, OP_HLT, 0);
    vpct = 100; rpct = 100;
    run_prog(1, 1'b0, 600);
    check("t6_beats", out_beats, 3);
    check("t6_acc", acc_b, 16'h1234);
    check("t6_pc", imem_addr_b, 203);

    // random programs with random handshake stalls
    for (int t = 0; t < 15; t++) begin
      ok = 1'b0;
      for (tries = 0; tries < 200 && !ok; tries++) begin
        clear_prog();
        for (int i = 0; i < 32; i++) begin
          prog_op[i]  = $urandom_range(0, 15);
          prog_arg[i] = $urandom_range(0, 255);
        end
        for (int i = 0; i < 300; i++)
          in_vals.push_back(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255));
        model_run(8, 5, 4, 0, ok, d0, d1, d2, d3, d4);
        exp_a.delete();
      end
      if (ok) begin
        vpct = (t < 3) ? 100 : $urandom_range(30, 100);
        rpct = (t < 3) ? 100 : $urandom_range(30, 100);
        run_prog(0, 1'b0, 4000);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
